// File: rtl/spi_slave_phy_if.sv
// spi_slave_phy_if: SPI pins plus the byte-level handshake between the SPI slave PHY and the command decoder.
interface spi_slave_phy_if;
    logic       mselect;
    logic       mclk;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       sel_start;
    logic       sel_end;
    logic       tx_underrun;
    modport slave (
        input  mselect, mclk, mosi, tx_data, tx_load,
        output miso, miso_oe, rx_data, rx_valid, sel_start, sel_end, tx_underrun
    );
    modport master (
        output mselect, mclk, mosi, tx_data, tx_load,
        input  miso, miso_oe, rx_data, rx_valid, sel_start, sel_end, tx_underrun
    );
endinterface

// File: rtl/spi_slave_phy.sv
// spi_slave_phy: synchronises SPI pins into clk, deserialises MOSI into byte strobes and serialises reply bytes onto MISO.
module spi_slave_phy #(
    parameter bit         CPOL        = 1'b1,
    parameter bit         CPHA        = 1'b1,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input logic            clk,
    input logic            reset_n,
    spi_slave_phy_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sel_q, sck_q, mosi_q;
    logic sck_prev, full;
    logic [2:0] cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr, rbuf, load_byte, rx_next;
    logic sel_s, sck_s, mosi_s, start, stop, run, tgl, lead, trail, sample, shift, load;
    assign sel_s    = sel_q[SYNC_STAGES-1];
    assign sck_s    = sck_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign bus.miso = tx_sr[7];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_n;
    end
    // A coincident tx_load wins over the buffer so the reply is never an underrun.
    always_comb begin
        state_n   = sel_s ? IDLE : ACTIVE;
        start     = state == IDLE && !sel_s;
        stop      = state == ACTIVE && sel_s;
        run       = state == ACTIVE && !sel_s;
        tgl       = sck_s != sck_prev;
        lead      = tgl && sck_s != CPOL;
        trail     = tgl && sck_s == CPOL;
        sample    = run && (CPHA ? trail : lead);
        shift     = run && (CPHA ? lead : trail);
        load      = (start && !CPHA) || (shift && cnt == 3'd0);
        load_byte = bus.tx_load ? bus.tx_data : full ? rbuf : IDLE_BYTE;
        rx_next   = {rx_sr, mosi_s};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q           <= '1;
            sck_q           <= {SYNC_STAGES{CPOL}};
            mosi_q          <= '0;
            sck_prev        <= CPOL;
            cnt             <= '0;
            rx_sr           <= '0;
            tx_sr           <= '0;
            rbuf            <= '0;
            full            <= 1'b0;
            bus.miso_oe     <= 1'b0;
            bus.rx_data     <= '0;
            bus.rx_valid    <= 1'b0;
            bus.sel_start   <= 1'b0;
            bus.sel_end     <= 1'b0;
            bus.tx_underrun <= 1'b0;
        end else begin
            sel_q           <= {sel_q[SYNC_STAGES-2:0], bus.mselect};
            sck_q           <= {sck_q[SYNC_STAGES-2:0], bus.mclk};
            mosi_q          <= {mosi_q[SYNC_STAGES-2:0], bus.mosi};
            sck_prev        <= sck_s;
            bus.miso_oe     <= state_n == ACTIVE;
            bus.sel_start   <= start;
            bus.sel_end     <= stop;
            bus.rx_valid    <= 1'b0;
            bus.tx_underrun <= load && !bus.tx_load && !full;
            if (start) cnt <= '0;
            if (sample) begin
                rx_sr <= rx_next[6:0];
                cnt   <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    bus.rx_data  <= rx_next;
                    bus.rx_valid <= 1'b1;
                end
            end
            if (load) tx_sr <= load_byte;
            else if (shift) tx_sr <= {tx_sr[6:0], 1'b0};
            if (load) full <= 1'b0;
            else if (bus.tx_load) begin
                rbuf <= bus.tx_data;
                full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_phy.sv
// tb_spi_slave_phy: directed bench for a mode 3 instance (a) and a mode 0 instance (b) of the SPI slave PHY.
module tb_spi_slave_phy;
    localparam int HP = 8;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int a_rxn = 0, a_und = 0, a_en = 0, b_rxn = 0, b_und = 0;
    spi_slave_phy_if a_if ();
    spi_slave_phy_if b_if ();
    spi_slave_phy #(.CPOL(1'b1), .CPHA(1'b1)) dut_a (.clk(clk), .reset_n(reset_n), .bus(a_if));
    spi_slave_phy #(.CPOL(1'b0), .CPHA(1'b0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(b_if));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (a_if.rx_valid) a_rxn++;
        if (a_if.tx_underrun) a_und++;
        if (a_if.sel_end) a_en++;
        if (b_if.rx_valid) b_rxn++;
        if (b_if.tx_underrun) b_und++;
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic set_sel(input bit m, input logic v);
        if (m) a_if.mselect = v; else b_if.mselect = v;
    endtask
    task automatic set_sck(input bit m, input logic v);
        if (m) a_if.mclk = v; else b_if.mclk = v;
    endtask
    task automatic set_mosi(input bit m, input logic v);
        if (m) a_if.mosi = v; else b_if.mosi = v;
    endtask
    task automatic load_tx(input bit m, input logic [7:0] d);
        if (m) begin a_if.tx_data = d; a_if.tx_load = 1'b1; end
        else begin b_if.tx_data = d; b_if.tx_load = 1'b1; end
        tick(1);
        a_if.tx_load = 1'b0;
        b_if.tx_load = 1'b0;
    endtask
    // Master side: mode 3 drives on falling/samples on rising; mode 0 drives before rising/samples on rising.
    task automatic xfer(input bit m, input logic [7:0] d, input int nb, input bit inj,
                        input logic [7:0] inj_d, output logic [7:0] r);
        r = '0;
        for (int i = 7; i >= 8 - nb; i--) begin
            if (m) begin
                set_sck(1'b1, 1'b0);
                set_mosi(1'b1, d[i]);
                if (inj && i == 7) begin
                    tick(2);
                    a_if.tx_data = inj_d;
                    a_if.tx_load = 1'b1;
                    tick(1);
                    a_if.tx_load = 1'b0;
                    tick(HP - 3);
                end else tick(HP);
                r[i] = a_if.miso;
                set_sck(1'b1, 1'b1);
                tick(HP);
            end else begin
                set_mosi(1'b0, d[i]);
                tick(HP);
                r[i] = b_if.miso;
                set_sck(1'b0, 1'b1);
                tick(HP);
                set_sck(1'b0, 1'b0);
            end
        end
    endtask
    task automatic decoder(input logic [7:0] exp_rx, input logic [7:0] reply);
        int c = 0;
        while (a_if.rx_valid !== 1'b1 && c < 400) begin
            tick(1);
            c++;
        end
        n_chk++;
        if (a_if.rx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL decoder_timeout: got rx_valid %b, expected 1", a_if.rx_valid);
        end else begin
            n_chk++;
            if (a_if.rx_data !== exp_rx) begin
                n_fail++;
                $display("FAIL decoder_rx: got %h, expected %h", a_if.rx_data, exp_rx);
            end
            a_if.tx_data = reply;
            a_if.tx_load = 1'b1;
            tick(1);
            a_if.tx_load = 1'b0;
        end
    endtask
    task automatic test_reset;
        tick(3);
        n_chk++;
        if ({a_if.miso, a_if.miso_oe, a_if.rx_data, a_if.rx_valid, a_if.sel_start, a_if.sel_end, a_if.tx_underrun} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_a: got %b, expected 0", {a_if.miso, a_if.miso_oe, a_if.rx_data, a_if.rx_valid, a_if.sel_start, a_if.sel_end, a_if.tx_underrun});
        end
        n_chk++;
        if ({b_if.miso, b_if.miso_oe, b_if.rx_data, b_if.rx_valid, b_if.sel_start, b_if.sel_end, b_if.tx_underrun} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_b: got %b, expected 0", {b_if.miso, b_if.miso_oe, b_if.rx_data, b_if.rx_valid, b_if.sel_start, b_if.sel_end, b_if.tx_underrun});
        end
        reset_n = 1'b1;
        tick(4);
    endtask
    task automatic test_mode3_echo;
        logic [7:0] r;
        int u0 = a_und;
        int n0 = a_rxn;
        set_sel(1'b1, 1'b0);
        tick(2);
        n_chk++;
        if (a_if.sel_start !== 1'b0) begin n_fail++; $display("FAIL sel_start_early: got %b, expected 0", a_if.sel_start); end
        tick(1);
        n_chk++;
        if (a_if.sel_start !== 1'b1) begin n_fail++; $display("FAIL sel_start_latency: got %b, expected 1", a_if.sel_start); end
        n_chk++;
        if (a_if.miso_oe !== 1'b1) begin n_fail++; $display("FAIL miso_oe_on: got %b, expected 1", a_if.miso_oe); end
        tick(4);
        fork
            xfer(1'b1, 8'h11, 8, 1'b0, 8'h00, r);
            decoder(8'h11, 8'h22);
        join
        n_chk++;
        if (r !== 8'hFF) begin n_fail++; $display("FAIL echo_first_reply: got %h, expected ff", r); end
        n_chk++;
        if (a_und - u0 != 1) begin n_fail++; $display("FAIL echo_underrun: got %0d, expected 1", a_und - u0); end
        xfer(1'b1, 8'h42, 8, 1'b0, 8'h00, r);
        tick(2);
        n_chk++;
        if (r !== 8'h22) begin n_fail++; $display("FAIL echo_second_reply: got %h, expected 22", r); end
        n_chk++;
        if (a_if.rx_data !== 8'h42) begin n_fail++; $display("FAIL echo_rx_42: got %h, expected 42", a_if.rx_data); end
        n_chk++;
        if (a_rxn - n0 != 2) begin n_fail++; $display("FAIL echo_rx_count: got %0d, expected 2", a_rxn - n0); end
        n_chk++;
        if (a_und - u0 != 1) begin n_fail++; $display("FAIL echo_no_second_underrun: got %0d, expected 1", a_und - u0); end
        set_sel(1'b1, 1'b1);
        tick(6);
        n_chk++;
        if (a_if.miso_oe !== 1'b0) begin n_fail++; $display("FAIL miso_oe_off: got %b, expected 0", a_if.miso_oe); end
    endtask
    task automatic test_deselect;
        logic [7:0] r;
        int e0 = a_en;
        int n0 = a_rxn;
        set_sel(1'b1, 1'b0);
        tick(6);
        xfer(1'b1, 8'hAB, 4, 1'b0, 8'h00, r);
        set_sel(1'b1, 1'b1);
        tick(6);
        n_chk++;
        if (a_en - e0 != 1) begin n_fail++; $display("FAIL desel_sel_end: got %0d, expected 1", a_en - e0); end
        n_chk++;
        if (a_rxn != n0) begin n_fail++; $display("FAIL desel_no_rx_valid: got %0d, expected %0d", a_rxn, n0); end
        n_chk++;
        if (a_if.miso_oe !== 1'b0) begin n_fail++; $display("FAIL desel_miso_oe: got %b, expected 0", a_if.miso_oe); end
        set_sel(1'b1, 1'b0);
        tick(6);
        xfer(1'b1, 8'h5A, 8, 1'b0, 8'h00, r);
        tick(2);
        n_chk++;
        if (a_if.rx_data !== 8'h5A) begin n_fail++; $display("FAIL desel_next_rx: got %h, expected 5a", a_if.rx_data); end
        n_chk++;
        if (a_rxn - n0 != 1) begin n_fail++; $display("FAIL desel_next_count: got %0d, expected 1", a_rxn - n0); end
        set_sel(1'b1, 1'b1);
        tick(6);
    endtask
    task automatic test_bypass_overwrite;
        logic [7:0] r;
        int u0 = a_und;
        load_tx(1'b1, 8'h11);
        load_tx(1'b1, 8'h33);
        set_sel(1'b1, 1'b0);
        tick(6);
        xfer(1'b1, 8'h00, 8, 1'b0, 8'h00, r);
        n_chk++;
        if (r !== 8'h33) begin n_fail++; $display("FAIL overwrite_reply: got %h, expected 33", r); end
        n_chk++;
        if (a_und != u0) begin n_fail++; $display("FAIL overwrite_underrun: got %0d, expected 0", a_und - u0); end
        xfer(1'b1, 8'h00, 8, 1'b1, 8'h77, r);
        n_chk++;
        if (r !== 8'h77) begin n_fail++; $display("FAIL bypass_reply: got %h, expected 77", r); end
        n_chk++;
        if (a_und != u0) begin n_fail++; $display("FAIL bypass_underrun: got %0d, expected 0", a_und - u0); end
        xfer(1'b1, 8'h00, 8, 1'b0, 8'h00, r);
        n_chk++;
        if (r !== 8'hFF) begin n_fail++; $display("FAIL bypass_then_idle: got %h, expected ff", r); end
        n_chk++;
        if (a_und - u0 != 1) begin n_fail++; $display("FAIL bypass_then_underrun: got %0d, expected 1", a_und - u0); end
        set_sel(1'b1, 1'b1);
        tick(6);
    endtask
    task automatic test_mode0;
        logic [7:0] r;
        int u0 = b_und;
        int n0 = b_rxn;
        load_tx(1'b0, 8'hC3);
        set_sel(1'b0, 1'b0);
        tick(6);
        n_chk++;
        if (b_if.miso !== 1'b1) begin n_fail++; $display("FAIL mode0_first_bit: got %b, expected 1", b_if.miso); end
        n_chk++;
        if (b_und != u0) begin n_fail++; $display("FAIL mode0_start_underrun: got %0d, expected 0", b_und - u0); end
        xfer(1'b0, 8'h3C, 8, 1'b0, 8'h00, r);
        tick(2);
        n_chk++;
        if (r !== 8'hC3) begin n_fail++; $display("FAIL mode0_reply: got %h, expected c3", r); end
        n_chk++;
        if (b_if.rx_data !== 8'h3C) begin n_fail++; $display("FAIL mode0_rx: got %h, expected 3c", b_if.rx_data); end
        n_chk++;
        if (b_rxn - n0 != 1) begin n_fail++; $display("FAIL mode0_rx_count: got %0d, expected 1", b_rxn - n0); end
        set_sel(1'b0, 1'b1);
        tick(6);
    endtask
    task automatic test_reset_mid;
        logic [7:0] r;
        int u0;
        int n0 = a_rxn;
        set_sel(1'b1, 1'b0);
        tick(6);
        xfer(1'b1, 8'hE0, 3, 1'b0, 8'h00, r);
        load_tx(1'b1, 8'h99);
        n_chk++;
        if (a_if.miso_oe !== 1'b1) begin n_fail++; $display("FAIL pre_reset_oe: got %b, expected 1", a_if.miso_oe); end
        reset_n = 1'b0;
        #1;
        n_chk++;
        if ({a_if.miso, a_if.miso_oe, a_if.rx_data, a_if.rx_valid, a_if.sel_start, a_if.sel_end, a_if.tx_underrun} !== 14'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %b, expected 0", {a_if.miso, a_if.miso_oe, a_if.rx_data, a_if.rx_valid, a_if.sel_start, a_if.sel_end, a_if.tx_underrun});
        end
        set_sel(1'b1, 1'b1);
        tick(2);
        reset_n = 1'b1;
        tick(4);
        n_chk++;
        if (a_rxn != n0) begin n_fail++; $display("FAIL reset_no_strobe: got %0d, expected %0d", a_rxn, n0); end
        u0 = a_und;
        set_sel(1'b1, 1'b0);
        tick(6);
        xfer(1'b1, 8'h0F, 8, 1'b0, 8'h00, r);
        tick(2);
        n_chk++;
        if (r !== 8'hFF) begin n_fail++; $display("FAIL post_reset_reply: got %h, expected ff", r); end
        n_chk++;
        if (a_if.rx_data !== 8'h0F) begin n_fail++; $display("FAIL post_reset_rx: got %h, expected 0f", a_if.rx_data); end
        n_chk++;
        if (a_und - u0 != 1) begin n_fail++; $display("FAIL post_reset_underrun: got %0d, expected 1", a_und - u0); end
        set_sel(1'b1, 1'b1);
        tick(6);
    endtask
    initial begin
        a_if.mselect = 1'b1; a_if.mclk = 1'b1; a_if.mosi = 1'b0; a_if.tx_data = '0; a_if.tx_load = 1'b0;
        b_if.mselect = 1'b1; b_if.mclk = 1'b0; b_if.mosi = 1'b0; b_if.tx_data = '0; b_if.tx_load = 1'b0;
        test_reset();
        test_mode3_echo();
        test_deselect();
        test_bypass_overwrite();
        test_mode0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_phy.md
# spi_slave_phy

- Byte-level SPI slave front end that sits directly upstream of the command decoder in `top`.
- Synchronises the external `mselect`, `mclk` and `mosi` pins into the `clk` domain and deserialises MOSI into bytes, each delivered with a one-cycle strobe.
- Serialises the decoder's reply byte onto MISO during the following byte.
- Replaces the decoder's ad-hoc pin handling; the decoder sees only byte strobes and select start/end events.

## Interface
- `CPOL`, 1: idle level of `mclk`.
- `CPHA`, 1: 0 means sample on the leading edge; 1 means sample on the trailing edge.
- `SYNC_STAGES`, 2: flip-flops per synchroniser; minimum 2.
- `IDLE_BYTE`, 8'hFF: byte shifted out when no reply is pending.

Ports:
- `clk` in 1: the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `mselect` in 1: chip select, active low, asynchronous to `clk`.
- `mclk` in 1: SPI bit clock, asynchronous to `clk`.
- `mosi` in 1: serial data in.
- `miso` out 1: serial data out.
- `miso_oe` out 1: MISO output enable; high while selected.
- `rx_data` out 8: last complete received byte, MSB-first.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `tx_data` in 8: reply byte.
- `tx_load` in 1: one-cycle strobe; captures `tx_data` into the reply buffer.
- `sel_start` out 1: one-cycle pulse on the synchronised `mselect` falling edge.
- `sel_end` out 1: one-cycle pulse on the synchronised `mselect` rising edge.
- `tx_underrun` out 1: one-cycle pulse when `IDLE_BYTE` is loaded because the buffer was empty.

## Operation
- **Synchronisers.** `mselect`, `mclk` and `mosi` each pass through `SYNC_STAGES` flip-flops. Edges are detected on the synchronised `mclk` against its previous value.
- **Edge roles.** The leading edge is a transition away from `CPOL`.
  - Sample edge: the leading edge when CPHA=0, the trailing edge when CPHA=1.
  - Shift edge: the other edge.
- **States.**
  - IDLE: deselected.
  - ACTIVE: selected; tracks a 3-bit bit counter and the 8-bit tx and rx shift registers.
- **IDLE → ACTIVE** on synchronised `mselect`=0.
  - Pulse `sel_start`.
  - Clear the bit counter.
  - Assert `miso_oe`.
  - If CPHA=0, perform a byte load immediately.
- **ACTIVE → IDLE** on synchronised `mselect`=1, at any point.
  - Pulse `sel_end`.
  - Discard the partial byte; no `rx_valid`.
  - Deassert `miso_oe`.
  - The reply buffer keeps its contents.
- **Sample edge.** Shift `mosi` into the LSB of the rx shift register and increment the bit counter. When the counter wraps 7→0, copy the register to `rx_data` and pulse `rx_valid` in the same cycle.
- **Shift edge.**
  - CPHA=1: at bit count 0 perform a byte load, otherwise shift the tx register left.
  - CPHA=0: shift left; at bit count 0 (byte just completed) perform a byte load instead.
- **Byte load.**
  - Buffer full: the tx register takes the buffer and the buffer becomes empty.
  - Buffer empty: the tx register takes `IDLE_BYTE` and `tx_underrun` pulses.
- **`miso`** is always the tx register MSB.
- **Reply buffer.**
  - `tx_load` writes the buffer and marks it full.
  - A second `tx_load` before consumption overwrites the first.
  - `tx_load` in the same cycle as a byte load bypasses: `tx_data` goes straight to the tx register, the buffer ends empty, and there is no underrun.

## Timing
- **Reset values:** `miso`=0, `miso_oe`=0, `rx_data`=0, `rx_valid`=0, `sel_start`=0, `sel_end`=0, `tx_underrun`=0. The buffer is empty, the state is IDLE, and the synchronisers reset to `mselect`=1 and `mclk`=`CPOL`. Reset mid-byte aborts with no strobes.
- **Pin to event:** SYNC_STAGES+1 `clk` cycles from a pin transition to the resulting strobe or edge action.
- **`miso` update:** changes on the cycle after the detected shift edge.
- **Input constraints:**
  - `mclk` half-period ≥ SYNC_STAGES+2 `clk` cycles.
  - `mosi` stable for SYNC_STAGES+1 cycles around each sample edge.
- **Reply deadline:** the reply to byte N must be `tx_load`ed before the first shift edge of byte N+1 is detected. The earliest useful point is the `rx_valid` cycle of byte N.
- **Mode 3 spacing:** with CPHA=1 the master must leave ≥ 2 `clk` cycles between the last sample edge and the next leading edge.

## Test plan
- **Mode 3 echo.**
  - Stimulus: select; send 0x11; decoder model `tx_load`s 0x22 on `rx_valid`; send 0x42.
  - Required: `rx_data` 0x11 then 0x42; master reads 0xFF (with `tx_underrun`) then 0x22.
- **Mid-byte deselect.**
  - Stimulus: 4 bits of 0xAB, then `mselect`=1.
  - Required: `sel_end` pulses, no `rx_valid`, `miso_oe`=0. The next select plus 0x5A gives `rx_data`=0x5A.
- **Bypass and overwrite.**
  - Stimulus: `tx_load` 0x11 then 0x33 before consumption; next byte reads 0x33. Then `tx_load` 0x77 coincident with a byte load.
  - Required: the 0x77 byte reads back 0x77, no underrun, and the following byte reads `IDLE_BYTE`.
- **Mode 0** (CPOL=0, CPHA=0).
  - Stimulus: buffer holds 0xC3 before select.
  - Required: MISO bit 7 (1) is valid before the first rising `mclk`; the master reads 0xC3; MOSI 0x3C yields `rx_data`=0x3C.
- **Reset.**
  - Stimulus: assert `reset_n`=0 mid-transfer.
  - Required: all outputs 0 within the same cycle (asynchronous). After release, a fresh select works and the first reply is `IDLE_BYTE`.
